affine_input_pipe: RTL and testbench

AFFINE_INPUT_PIPE -- requirements
Module: affine_input_pipe

---
 rtl/affine_input_pipe.sv | 108 ++++++++++
 tb/tb_affine_input_pipe.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/affine_input_pipe.sv
// Input stage of the S-box datapath: applies the AES inverse affine transform
// on decrypt bytes (identity on encrypt bytes), tags each byte with its
// position in the block, and buffers {byte, idx} in a 2-entry FIFO whose
// head is presented combinationally from registers (1-cycle latency).
module affine_input_pipe #(
  parameter  int unsigned BLOCK_BYTES = 16,
  localparam int unsigned IW          = $clog2(BLOCK_BYTES)
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          CLR,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic          IN_MODE,
  input  logic [7:0]    IN_DATA,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [7:0]    OUT_DATA,
  output logic [IW-1:0] OUT_IDX,
  output logic          OUT_LAST
);

  localparam logic [7:0]    AFFINE_C = 8'h05;
  localparam logic [IW-1:0] IDX_MAX  = IW'(BLOCK_BYTES - 1);

  logic [1:0]    occ;
  logic [IW-1:0] in_idx;
  logic [7:0]    head_data;
  logic [IW-1:0] head_idx;
  logic [7:0]    tail_data;
  logic [IW-1:0] tail_idx;
  logic [7:0]    xf_data;
  logic          push;
  logic          pop;

  // Handshake status depends only on registered occupancy
  assign IN_READY  = (occ != 2'd2);
  assign OUT_VALID = (occ != 2'd0);
  assign OUT_DATA  = head_data;
  assign OUT_IDX   = head_idx;
  assign OUT_LAST  = (head_idx == IDX_MAX);

  assign push = IN_VALID & IN_READY;
  assign pop  = OUT_VALID & OUT_READY;

  // Inverse affine: bit i = X[i+2] ^ X[i+5] ^ X[i+7] ^ C[i] (indices mod 8),
  // written as right-rotations by 2, 5 and 7
  always_comb begin
    xf_data = IN_DATA;
    if (IN_MODE) begin
      xf_data = {IN_DATA[1:0], IN_DATA[7:2]}
              ^ {IN_DATA[4:0], IN_DATA[7:5]}
              ^ {IN_DATA[6:0], IN_DATA[7]}
              ^ AFFINE_C;
    end
  end

  // FIFO storage, occupancy and block byte counter; CLR overrides transfers
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      occ       <= '0;
      in_idx    <= '0;
      head_data <= '0;
      head_idx  <= '0;
      tail_data <= '0;
      tail_idx  <= '0;
    end else if (CLR) begin
      occ    <= '0;
      in_idx <= '0;
    end else begin
      if (push) begin
        in_idx <= (in_idx == IDX_MAX) ? '0 : in_idx + 1'b1;
      end
      // Head is always slot 0; a pop shifts the tail forward so the head
      // register feeds the outputs directly.
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            head_data <= xf_data;
            head_idx  <= in_idx;
          end else begin
            tail_data <= xf_data;
            tail_idx  <= in_idx;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head_data <= tail_data;
          head_idx  <= tail_idx;
          occ       <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            head_data <= xf_data;
            head_idx  <= in_idx;
          end else begin
            head_data <= tail_data;
            head_idx  <= tail_idx;
            tail_data <= xf_data;
            tail_idx  <= in_idx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_affine_input_pipe.sv
// Self-checking bench for affine_input_pipe: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_affine_input_pipe;

  localparam int BB = 16;

  logic       CLK;
  logic       RSTn;
  logic       CLR;
  logic       IN_VALID;
  logic       IN_READY;
  logic       IN_MODE;
  logic [7:0] IN_DATA;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic [7:0] OUT_DATA;
  logic [3:0] OUT_IDX;
  logic       OUT_LAST;

  affine_input_pipe #(.BLOCK_BYTES(BB)) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .CLR       (CLR),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_MODE   (IN_MODE),
    .IN_DATA   (IN_DATA),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_DATA  (OUT_DATA),
    .OUT_IDX   (OUT_IDX),
    .OUT_LAST  (OUT_LAST)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: queue of {data, idx}, next idx, and "no transfer since reset"
  logic [15:0] q[$];
  int          m_idx = 0;
  bit          fresh = 1'b1;
  int          last_cnt;

  function automatic logic [7:0] ref_xform(input logic m, input logic [7:0] x);
    int v;
    int y;
    v = int'(x);
    if (!m) return x;
    // Standard AES inverse affine: rotl1 ^ rotl3 ^ rotl6 ^ 0x05
    y = ((v << 1) | (v >> 7)) ^ ((v << 3) | (v >> 5)) ^ ((v << 6) | (v >> 2)) ^ 5;
    return y[7:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    logic [15:0] h;
    chk("in_ready", 32'(IN_READY), 32'(q.size() < 2));
    chk("out_valid", 32'(OUT_VALID), 32'(q.size() > 0));
    if (q.size() > 0) begin
      h = q[0];
      chk("out_data", 32'(OUT_DATA), 32'(h[15:8]));
      chk("out_idx", 32'(OUT_IDX), 32'(h[7:0]));
      chk("out_last", 32'(OUT_LAST), 32'(h[7:0] == 8'(BB - 1)));
    end else if (fresh) begin
      chk("rst_data", 32'(OUT_DATA), 32'h0);
      chk("rst_idx", 32'(OUT_IDX), 32'h0);
      chk("rst_last", 32'(OUT_LAST), 32'h0);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_idx = 0;
    fresh = 1'b1;
  endtask

  // One clock: drive inputs, check pre-edge outputs, clock, update model
  task automatic cycle(input logic v, input logic m, input logic [7:0] d,
                       input logic r, input logic c);
    bit do_push;
    bit do_pop;
    IN_VALID  = v;
    IN_MODE   = m;
    IN_DATA   = d;
    OUT_READY = r;
    CLR       = c;
    #1;
    check_state();
    do_push = !c && v && (q.size() < 2);
    do_pop  = !c && r && (q.size() > 0);
    @(posedge CLK);
    #1;
    if (c) begin
      q.delete();
      m_idx = 0;
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back({ref_xform(m, d), 8'(m_idx)});
        m_idx = (m_idx + 1) % BB;
        fresh = 1'b0;
      end
    end
  endtask

  initial begin
    RSTn = 1'b0; CLR = 1'b0; IN_VALID = 1'b0; IN_MODE = 1'b0;
    IN_DATA = 8'h00; OUT_READY = 1'b0;
    model_reset();
    #3;
    check_state();
    repeat (2) @(posedge CLK);
    #3;
    RSTn = 1'b1;
    // Outputs hold reset values with idle input
    cycle(1'b0, 1'b0, 8'hA5, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 8'h5A, 1'b0, 1'b0);

    // Decrypt vectors, 1-cycle latency
    cycle(1'b1, 1'b1, 8'h63, 1'b1, 1'b0);
    chk("inv63", 32'(OUT_DATA), 32'h00);
    chk("inv63_valid", 32'(OUT_VALID), 32'h1);
    cycle(1'b1, 1'b1, 8'h7C, 1'b1, 1'b0);
    chk("inv7c", 32'(OUT_DATA), 32'h01);
    cycle(1'b1, 1'b1, 8'hED, 1'b1, 1'b0);
    chk("inved", 32'(OUT_DATA), 32'hCA);
    chk("inved_idx", 32'(OUT_IDX), 32'h2);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Encrypt stream 0x00..0x0F back-to-back from idx 0
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b0, 8'(i), 1'b1, 1'b0);
      chk("str_data", 32'(OUT_DATA), 32'(i));
      chk("str_idx", 32'(OUT_IDX), 32'(i));
      chk("str_last", 32'(OUT_LAST), 32'(i == 15));
      chk("str_rdy", 32'(IN_READY), 32'h1);
    end
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Backpressure: two accepted, third held, then in-order drain
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 8'hAA, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 8'hBB, 1'b0, 1'b0);
    chk("bp_full", 32'(IN_READY), 32'h0);
    cycle(1'b1, 1'b0, 8'hCC, 1'b0, 1'b0);
    chk("bp_hold_data", 32'(OUT_DATA), 32'hAA);
    chk("bp_hold_rdy", 32'(IN_READY), 32'h0);
    cycle(1'b1, 1'b0, 8'hCC, 1'b1, 1'b0);
    chk("bp_d1", 32'(OUT_IDX), 32'h1);
    cycle(1'b1, 1'b0, 8'hCC, 1'b1, 1'b0);
    chk("bp_d2", 32'(OUT_IDX), 32'h2);
    chk("bp_d2_data", 32'(OUT_DATA), 32'hCC);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("bp_empty", 32'(OUT_VALID), 32'h0);

    // Occupancy 1 with simultaneous push/pop across the idx wrap
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 8'h40, 1'b0, 1'b0);
    last_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (OUT_LAST) last_cnt++;
      cycle(1'b1, 1'b1, 8'(8'h41 + i), 1'b1, 1'b0);
      chk("pp_valid", 32'(OUT_VALID), 32'h1);
      chk("pp_rdy", 32'(IN_READY), 32'h1);
    end
    chk("pp_last_cnt", 32'(last_cnt), 32'h1);

    // CLR beats simultaneous push and pop
    cycle(1'b1, 1'b0, 8'h99, 1'b1, 1'b1);
    chk("clr_empty", 32'(OUT_VALID), 32'h0);
    cycle(1'b1, 1'b0, 8'h55, 1'b1, 1'b0);
    chk("clr_idx0", 32'(OUT_IDX), 32'h0);
    chk("clr_data", 32'(OUT_DATA), 32'h55);

    // Asynchronous reset between edges with two buffered bytes
    cycle(1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 8'h22, 1'b0, 1'b0);
    #2;
    RSTn = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", 32'(OUT_VALID), 32'h0);
    chk("arst_rdy", 32'(IN_READY), 32'h1);
    chk("arst_data", 32'(OUT_DATA), 32'h0);
    #1;
    RSTn = 1'b1;
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 8'h63, 1'b1, 1'b0);
    chk("arst_idx0", 32'(OUT_IDX), 32'h0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle(1'(($urandom % 4) != 0), 1'($urandom % 2), 8'($urandom),
            1'(($urandom % 3) != 0), 1'(($urandom % 40) == 0));
    end
    check_state();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
